// File: rtl/aes_ctrl_pkg.sv
// Shared constants and state encoding for the AES-256 round sequencing controller.
package aes_ctrl_pkg;

    localparam int NR        = 14;
    localparam int KEY_WORDS = 16;
    localparam int WORD_W    = 16;
    localparam int ROUND_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        READY,
        INIT,
        ROUND,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/aes_key_word_loader.sv
// Streams 16-bit key words into the key register file and tracks key completeness.
module aes_key_word_loader
    import aes_ctrl_pkg::*;
#(
    parameter int KEY_WORDS = aes_ctrl_pkg::KEY_WORDS,
    parameter int WORD_W    = aes_ctrl_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              busy,
    input  logic              key_we,
    input  logic [WORD_W-1:0] key_word,
    output logic              key_wr_en,
    output logic [3:0]        key_wr_addr,
    output logic [WORD_W-1:0] key_wr_data,
    output logic              key_loaded,
    output logic              key_err,
    output logic              key_set,
    output logic              key_clear
);

    localparam logic [3:0] LAST_ADDR = 4'(KEY_WORDS - 1);

    logic              accept;
    logic [3:0]        wptr_reg, wptr_next;
    logic              key_wr_en_reg;
    logic [3:0]        key_wr_addr_reg;
    logic [WORD_W-1:0] key_wr_data_reg;
    logic              key_loaded_reg, key_loaded_next;
    logic              key_err_reg;

    assign accept    = key_we & ~busy;
    // Clearing acts on the strobe itself so ready drops before a stale key can be used.
    assign key_clear = accept & (wptr_reg == 4'd0);
    assign key_set   = key_wr_en_reg & (key_wr_addr_reg == LAST_ADDR);

    always_comb begin
        wptr_next       = wptr_reg;
        key_loaded_next = key_loaded_reg;
        if (accept) begin
            wptr_next = (wptr_reg == LAST_ADDR) ? 4'd0 : wptr_reg + 4'd1;
        end
        if (key_clear) begin
            key_loaded_next = 1'b0;
        end else if (key_set) begin
            key_loaded_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg        <= '0;
            key_wr_en_reg   <= 1'b0;
            key_wr_addr_reg <= '0;
            key_wr_data_reg <= '0;
            key_loaded_reg  <= 1'b0;
            key_err_reg     <= 1'b0;
        end else begin
            wptr_reg       <= wptr_next;
            key_wr_en_reg  <= accept;
            key_loaded_reg <= key_loaded_next;
            key_err_reg    <= key_we & busy;
            if (accept) begin
                key_wr_addr_reg <= wptr_reg;
                key_wr_data_reg <= key_word;
            end
        end
    end

    assign key_wr_en   = key_wr_en_reg;
    assign key_wr_addr = key_wr_addr_reg;
    assign key_wr_data = key_wr_data_reg;
    assign key_loaded  = key_loaded_reg;
    assign key_err     = key_err_reg;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequences key loading, the initial AddRoundKey and rounds 1..NR of the iterative AES-256 core.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int KEY_WORDS = aes_ctrl_pkg::KEY_WORDS,
    parameter int WORD_W    = aes_ctrl_pkg::WORD_W,
    parameter int NR        = aes_ctrl_pkg::NR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_we,
    input  logic [WORD_W-1:0] key_word,
    output logic              key_wr_en,
    output logic [3:0]        key_wr_addr,
    output logic [WORD_W-1:0] key_wr_data,
    output logic              key_loaded,
    output logic              key_err,
    input  logic              start,
    output logic              ready,
    output logic              busy,
    output logic              ld_state,
    output logic              ks_en,
    output logic              round_en,
    output logic [3:0]        round_idx,
    output logic              final_round,
    output logic              done
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NR);

    ctrl_state_t        state_reg, state_next;
    logic [ROUND_W-1:0] round_reg, round_next;
    logic ready_reg, ready_next;
    logic busy_reg, busy_next;
    logic ld_state_reg, ld_state_next;
    logic ks_en_reg, ks_en_next;
    logic round_en_reg, round_en_next;
    logic final_round_reg, final_round_next;
    logic done_reg, done_next;
    logic key_lock, key_set, key_clear, start_ok;

    // Key writes are refused from INIT until the DONE cycle has passed.
    assign key_lock = (state_reg == INIT) || (state_reg == ROUND) || (state_reg == DONE);
    assign start_ok = start & ready_reg & ~key_we;

    aes_key_word_loader #(
        .KEY_WORDS (KEY_WORDS),
        .WORD_W    (WORD_W)
    ) u_loader (
        .clk         (clk),
        .rst         (rst),
        .busy        (key_lock),
        .key_we      (key_we),
        .key_word    (key_word),
        .key_wr_en   (key_wr_en),
        .key_wr_addr (key_wr_addr),
        .key_wr_data (key_wr_data),
        .key_loaded  (key_loaded),
        .key_err     (key_err),
        .key_set     (key_set),
        .key_clear   (key_clear)
    );

    always_comb begin
        state_next = state_reg;
        round_next = round_reg;
        case (state_reg)
            IDLE: begin
                if (key_set && !key_clear) state_next = READY;
            end
            READY: begin
                if (key_clear) begin
                    state_next = IDLE;
                end else if (start_ok) begin
                    state_next = INIT;
                    round_next = '0;
                end
            end
            INIT: begin
                state_next = ROUND;
                round_next = {{(ROUND_W-1){1'b0}}, 1'b1};
            end
            ROUND: begin
                // Counter holds at NR; the exit to DONE is taken from that value.
                if (round_reg == LAST_ROUND) state_next = DONE;
                else                         round_next = round_reg + 1'b1;
            end
            DONE: begin
                if (start_ok) begin
                    state_next = INIT;
                    round_next = '0;
                end else begin
                    state_next = READY;
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs are decoded from the next state so every one is a flop.
        ready_next       = (state_next == READY) || (state_next == DONE);
        busy_next        = (state_next == INIT) || (state_next == ROUND);
        ld_state_next    = (state_next == INIT);
        round_en_next    = (state_next == ROUND);
        final_round_next = (state_next == ROUND) && (round_next == LAST_ROUND);
        ks_en_next       = (state_next == INIT) ||
                           ((state_next == ROUND) && (round_next != LAST_ROUND));
        done_next        = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            round_reg       <= '0;
            ready_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            ld_state_reg    <= 1'b0;
            ks_en_reg       <= 1'b0;
            round_en_reg    <= 1'b0;
            final_round_reg <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            round_reg       <= round_next;
            ready_reg       <= ready_next;
            busy_reg        <= busy_next;
            ld_state_reg    <= ld_state_next;
            ks_en_reg       <= ks_en_next;
            round_en_reg    <= round_en_next;
            final_round_reg <= final_round_next;
            done_reg        <= done_next;
        end
    end

    assign ready       = ready_reg;
    assign busy        = busy_reg;
    assign ld_state    = ld_state_reg;
    assign ks_en       = ks_en_reg;
    assign round_en    = round_en_reg;
    assign round_idx   = round_reg;
    assign final_round = final_round_reg;
    assign done        = done_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: stimulus queues cycle-stamped expectations, a monitor checks them.
module tb_aes_round_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_we = 1'b0;
    logic [15:0] key_word = '0;
    logic        start = 1'b0;
    logic        key_wr_en, key_loaded, key_err;
    logic [3:0]  key_wr_addr;
    logic [15:0] key_wr_data;
    logic        ready, busy, ld_state, ks_en, round_en, final_round, done;
    logic [3:0]  round_idx;

    aes_round_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .key_we      (key_we),
        .key_word    (key_word),
        .key_wr_en   (key_wr_en),
        .key_wr_addr (key_wr_addr),
        .key_wr_data (key_wr_data),
        .key_loaded  (key_loaded),
        .key_err     (key_err),
        .start       (start),
        .ready       (ready),
        .busy        (busy),
        .ld_state    (ld_state),
        .ks_en       (ks_en),
        .round_en    (round_en),
        .round_idx   (round_idx),
        .final_round (final_round),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       ld, ks, ren, fin, dn;
        logic [3:0] idx;
    } ctl_t;

    typedef struct {
        int          cyc;
        logic [3:0]  addr;
        logic [15:0] data;
    } kw_t;

    ctl_t cq[$];
    kw_t  kq[$];
    int   eq[$];

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int wptr_m = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_ctl(input int t, input logic ld, input logic ks, input logic ren,
                            input logic [3:0] idx, input logic fin, input logic dn);
        ctl_t e;
        e.cyc = t; e.ld = ld; e.ks = ks; e.ren = ren; e.idx = idx; e.fin = fin; e.dn = dn;
        cq.push_back(e);
    endtask

    // Start accepted in cycle t: INIT at t+1, round r at t+1+r, done at t+16.
    task automatic push_block(input int t, input int last_r);
        push_ctl(t + 1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int r = 1; r <= last_r; r++) begin
            push_ctl(t + 1 + r, 1'b0, (r < 14), 1'b1, 4'(r), (r == 14), 1'b0);
        end
        if (last_r == 14) push_ctl(t + 16, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic write_word(input logic [15:0] w);
        kw_t e;
        key_we   = 1'b1;
        key_word = w;
        e.cyc  = cyc + 1;
        e.addr = 4'(wptr_m);
        e.data = w;
        kq.push_back(e);
        wptr_m = (wptr_m + 1) % 16;
        tick();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a transaction.
    always @(negedge clk) begin
        ctl_t e;
        kw_t  k;
        logic [10:0] act_v, exp_v;
        logic [3:0]  act_idx;
        while (cq.size() > 0 && cq[0].cyc < cyc) begin
            tests++; fails++;
            $display("FAIL ctl_missing cyc=%0d actual=none expected_at=%0d", cyc, cq[0].cyc);
            void'(cq.pop_front());
        end
        while (kq.size() > 0 && kq[0].cyc < cyc) begin
            tests++; fails++;
            $display("FAIL kwr_missing cyc=%0d actual=none expected_at=%0d", cyc, kq[0].cyc);
            void'(kq.pop_front());
        end
        while (eq.size() > 0 && eq[0] < cyc) begin
            tests++; fails++;
            $display("FAIL key_err_missing cyc=%0d actual=none expected_at=%0d", cyc, eq[0]);
            void'(eq.pop_front());
        end

        if (done) done_cnt++;
        if (ld_state || round_en || done) begin
            $display("[TB] cyc=%0d ctl ld=%b ks=%b ren=%b idx=%0d fin=%b done=%b",
                     cyc, ld_state, ks_en, round_en, round_idx, final_round, done);
            tests++;
            if (cq.size() == 0) begin
                fails++;
                $display("FAIL ctl_unexpected cyc=%0d actual=ld%b/ren%b/done%b required=idle",
                         cyc, ld_state, round_en, done);
            end else begin
                e = cq.pop_front();
                act_idx = e.dn ? e.idx : round_idx;
                act_v = {ld_state, ks_en, round_en, act_idx, final_round, done, busy, ready};
                exp_v = {e.ld, e.ks, e.ren, e.idx, e.fin, e.dn, e.ld | e.ren, e.dn};
                if (act_v !== exp_v || e.cyc != cyc) begin
                    fails++;
                    $display("FAIL ctl cyc=%0d actual=%h required=%h at_cyc=%0d",
                             cyc, act_v, exp_v, e.cyc);
                end
            end
        end

        if (key_wr_en) begin
            $display("[TB] cyc=%0d key_wr addr=%0d data=%h", cyc, key_wr_addr, key_wr_data);
            tests++;
            if (kq.size() == 0) begin
                fails++;
                $display("FAIL kwr_unexpected cyc=%0d actual=addr%0d required=no_write",
                         cyc, key_wr_addr);
            end else begin
                k = kq.pop_front();
                if (key_wr_addr !== k.addr || key_wr_data !== k.data || k.cyc != cyc) begin
                    fails++;
                    $display("FAIL kwr cyc=%0d actual=%0d/%h required=%0d/%h at_cyc=%0d",
                             cyc, key_wr_addr, key_wr_data, k.addr, k.data, k.cyc);
                end
            end
        end

        if (key_err) begin
            $display("[TB] cyc=%0d key_err", cyc);
            tests++;
            if (eq.size() == 0) begin
                fails++;
                $display("FAIL key_err_unexpected cyc=%0d actual=1 required=0", cyc);
            end else if (eq.pop_front() != cyc) begin
                fails++;
                $display("FAIL key_err_timing cyc=%0d actual=1 required=other_cycle", cyc);
            end
        end
    end

    initial begin
        int t;
        int d0;

        // Reset state
        repeat (3) tick();
        check("reset_outputs",
              {key_wr_en, key_wr_addr, key_wr_data, key_loaded, key_err, ready, busy,
               ld_state, ks_en, round_en, round_idx, final_round, done}, 64'd0);
        rst = 1'b0;
        tick();

        // 0x1111..0x8888 written twice, one word per cycle
        for (int i = 0; i < 32; i++) write_word(16'(((i % 8) + 1) * 16'h1111));
        key_we = 1'b0;
        check("key_loaded_not_early", key_loaded, 1'b0);
        tick();
        check("key_loaded_after_16", key_loaded, 1'b1);
        check("ready_after_16", ready, 1'b1);

        // Single block
        t = cyc;
        start = 1'b1;
        push_block(t, 14);
        tick();
        start = 1'b0;
        repeat (16) tick();
        check("ready_after_block", ready, 1'b1);

        // start held high: back-to-back blocks, two done pulses in 33 cycles
        d0 = done_cnt;
        t = cyc;
        start = 1'b1;
        push_block(t, 14);
        push_block(t + 16, 14);
        repeat (32) tick();
        start = 1'b0;
        tick();
        check("two_done_in_33", done_cnt - d0, 2);

        // key_we during round 5 is dropped and flagged
        t = cyc;
        start = 1'b1;
        push_block(t, 14);
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("round5_idx", round_idx, 4'd5);
        key_we = 1'b1;
        key_word = 16'hdead;
        eq.push_back(cyc + 1);
        tick();
        key_we = 1'b0;
        repeat (10) tick();

        // key_we and start together in READY with wptr=0: write wins
        check("wptr_model_zero", ready, 1'b1);
        start = 1'b1;
        write_word(16'h0f0f);
        key_we = 1'b0;
        start = 1'b0;
        check("word0_clears_loaded", key_loaded, 1'b0);
        check("word0_clears_ready", ready, 1'b0);
        repeat (3) tick();

        // Complete the key with words 1..15
        for (int i = 1; i < 16; i++) write_word(16'ha000 + 16'(i));
        key_we = 1'b0;
        tick();
        check("reload_ready", ready, 1'b1);

        // Reset at round 8
        t = cyc;
        start = 1'b1;
        push_block(t, 8);
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("round8_idx", round_idx, 4'd8);
        rst = 1'b1;
        tick();
        check("abort_outputs",
              {key_wr_en, key_wr_addr, key_wr_data, key_loaded, key_err, ready, busy,
               ld_state, ks_en, round_en, round_idx, final_round, done}, 64'd0);
        rst = 1'b0;
        wptr_m = 0;
        start = 1'b1;
        repeat (4) tick();
        start = 1'b0;
        check("start_ignored_ready", ready, 1'b0);
        check("start_ignored_busy", busy, 1'b0);

        // Reload and run one more block
        for (int i = 0; i < 16; i++) write_word(16'h5000 + 16'(i));
        key_we = 1'b0;
        tick();
        check("post_reset_ready", ready, 1'b1);
        t = cyc;
        start = 1'b1;
        push_block(t, 14);
        tick();
        start = 1'b0;
        repeat (18) tick();

        check("scoreboard_drained", cq.size() + kq.size() + eq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencing controller for the iterative AES-256 core. It collects the 256-bit key as sixteen 16-bit words into the key register file and tracks whether the key is complete. On a start handshake it drives the state datapath and on-the-fly key schedule through the initial AddRoundKey and rounds 1–14, then pulses `done`. It sits between the external key/plaintext interface and the round datapath inside `main`.

## Interface
- `KEY_WORDS`, default 16: key words per full AES-256 key.
- `WORD_W`, default 16: key word width.
- `NR`, default 14: number of AES rounds.
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `key_we` in 1: key word strobe. Already synchronised to `clk`. One cycle high means one word.
- `key_word` in WORD_W: key word, sampled when `key_we` is high.
- `key_wr_en` out 1: write strobe to the key register file.
- `key_wr_addr` out 4: word address.
- `key_wr_data` out WORD_W: registered copy of `key_word`.
- `key_loaded` out 1: all 16 words have been written since the last word-0 write.
- `key_err` out 1: one-cycle pulse; a `key_we` arrived while busy and was dropped.
- `start` in 1: request encryption of the plaintext held at the core input.
- `ready` out 1: registered; the controller can accept `start`.
- `busy` out 1: high from INIT through the last ROUND cycle.
- `ld_state` out 1: load plaintext XOR k0 into the state register; reload the round-key register from the key file.
- `ks_en` out 1: advance the key schedule one round key.
- `round_en` out 1: apply one round to the state register.
- `round_idx` out 4: current round, 0..14.
- `final_round` out 1: current round skips MixColumns.
- `done` out 1: one-cycle pulse; the ciphertext is valid in the state register.

## Operation
- States:
  - IDLE: key not complete.
  - READY: key complete, waiting for `start`.
  - INIT
  - ROUND
  - DONE
- Key loading:
  - A `key_we` outside INIT/ROUND/DONE writes to address `wptr`, then `wptr` increments and wraps 15→0.
  - Writing word 0 clears `key_loaded` and forces IDLE.
  - Writing word 15 sets `key_loaded` and moves to READY.
  - A partial reload therefore invalidates the key until all 16 words are rewritten.
- A `key_we` during INIT/ROUND/DONE is dropped: no write, `wptr` unchanged, `key_err` pulses next cycle.
- Start acceptance: `start & ready & !key_we`. In a cycle with both `key_we` and `start`, the write wins and `start` is dropped. The requester must re-assert.
- `start` while `ready`=0 is ignored, with no queuing.
- Round sequencing:
  - INIT: `ld_state`=1, `ks_en`=1, `round_idx`=0.
  - ROUND r=1..14: `round_en`=1, `round_idx`=r, `final_round`=(r==NR), `ks_en`=(r<NR).
  - DONE: `done`=1, then return to READY.
- Round counter: 4-bit, saturating at NR; it never wraps mid-operation.
- Reset values, all outputs: 0. `round_idx`=0, `wptr`=0, `key_loaded`=0, state IDLE.
- Reset mid-operation aborts immediately. The key must be reloaded.

## Timing
- All outputs are registered, including `key_wr_*`, one cycle after `key_we`.
- Start accepted at cycle T:
  - T+1: INIT.
  - T+2..T+15: rounds 1..14.
  - T+16: `done`, with `ready`=1 in the same cycle.
- Start-to-done latency: 16 cycles.
- Back-to-back: a `start` at T+16 is accepted, and the next INIT is at T+17.
- Exactly one of `ld_state` and `round_en` is high in any busy cycle.
- `ks_en` is high for 14 cycles per block.
- `key_loaded` rises the cycle after the word-15 `key_wr_en`, and `ready` rises in the same cycle.
- Idle `key_we` throughput: one word per cycle. Consecutive strobes are all written.

## Structure
- `aes_ctrl_pkg`:
  - State enum (IDLE, READY, INIT, ROUND, DONE).
  - Constants NR=14, KEY_WORDS=16, WORD_W=16, ROUND_W=4.
- Sub-module `aes_key_word_loader`:
  - Owns `wptr`, the `key_wr_*` registers, `key_loaded` and `key_err`.
  - Takes a `busy` input from the FSM.
- The FSM and round counter live in `aes_round_ctrl`.

## Test plan
- Reset, then write 16 words 0x1111, 0x2222, …, 0x8888 twice, one word per cycle:
  - Addresses 0..15 appear on `key_wr_addr` with matching data.
  - `key_loaded` and `ready` go to 1 after the 16th write.
- With the key loaded, pulse `start`:
  - `ld_state` at T+1.
  - `round_idx` steps 1..14 at T+2..T+15.
  - `final_round` is high only at T+15.
  - `ks_en` is low at T+15.
  - `done` at T+16.
- Hold `start` high continuously: a second INIT at T+17, and exactly two `done` pulses in 33 cycles.
- Pulse `key_we` at round 5:
  - `key_err` pulses.
  - No `key_wr_en`.
  - The round sequence and `done` timing are unchanged.
- Assert `key_we` and `start` in the same READY cycle with `wptr`=0:
  - Word 0 is written.
  - `key_loaded`=0, `ready`=0.
  - No INIT.
- Assert `rst` at round 8:
  - All outputs are 0 the next cycle, state IDLE.
  - A later `start` is ignored until 16 words are reloaded.
